// File: rtl/acc_collector_pkg.sv
// Shared definitions for the systolic array output collector.
package acc_collector_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    localparam int DEF_ROWS = 2;
    localparam int DEF_LAT  = 2;
    localparam int ACC_W    = 32;

    // Beat counter must reach LAT+ROWS, the final capture beat.
    function automatic int beat_width(int lat, int rows);
        return $clog2(lat + rows + 1);
    endfunction

endpackage

// File: rtl/acc_collector_if.sv
// Array-side capture signals and result-row stream of the collector.
interface acc_collector_if;
    import acc_collector_pkg::*;

    logic             valid;
    logic             start;
    logic [ACC_W-1:0] acc_in1;
    logic [ACC_W-1:0] acc_in2;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data0;
    logic [ACC_W-1:0] out_data1;
    logic [2:0]       out_row;
    logic             out_last;
    logic             busy;
    logic             overrun;

    modport slave (
        input  valid, start, acc_in1, acc_in2, out_ready,
        output out_valid, out_data0, out_data1, out_row, out_last, busy, overrun
    );

    modport master (
        output valid, start, acc_in1, acc_in2, out_ready,
        input  out_valid, out_data0, out_data1, out_row, out_last, busy, overrun
    );

endinterface

// File: rtl/acc_collector_tile_buffer.sv
// ROWS x 2 result tile: one write port per column, one row-wide read port.
module acc_tile_buffer
    import acc_collector_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int RW   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr0_en,
    input  logic [RW-1:0]    wr0_row,
    input  logic [ACC_W-1:0] wr0_data,
    input  logic             wr1_en,
    input  logic [RW-1:0]    wr1_row,
    input  logic [ACC_W-1:0] wr1_data,
    input  logic [RW-1:0]    rd_row,
    output logic [ACC_W-1:0] rd_data0,
    output logic [ACC_W-1:0] rd_data1
);

    logic [ACC_W-1:0] col0 [ROWS];
    logic [ACC_W-1:0] col1 [ROWS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                col0[i] <= '0;
                col1[i] <= '0;
            end
        end else begin
            if (wr0_en) col0[wr0_row] <= wr0_data;
            if (wr1_en) col1[wr1_row] <= wr1_data;
        end
    end

    assign rd_data0 = col0[rd_row];
    assign rd_data1 = col1[rd_row];

endmodule

// File: rtl/acc_collector.sv
// Deskews the two column accumulators into a result tile and drains it row by row.
module acc_collector
    import acc_collector_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int LAT  = DEF_LAT
) (
    input  logic            clk,
    input  logic            reset,
    acc_collector_if.slave  bus
);

    localparam int CW = beat_width(LAT, ROWS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    beat_q;
    logic [2:0]       ptr_q;
    logic             overrun_q;
    logic             fire;
    logic             drain;
    logic             last_row;
    logic             wr0_en, wr1_en;
    logic [RW-1:0]    wr0_row, wr1_row;
    logic [ACC_W-1:0] rd_data0, rd_data1;

    assign fire     = bus.valid & bus.start;
    assign drain    = (state_q == DRAIN);
    assign last_row = (ptr_q == 3'(ROWS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire) state_d = COLLECT;
            COLLECT: if (bus.valid && beat_q == CW'(LAT + ROWS)) state_d = DRAIN;
            DRAIN:   if (bus.out_ready && last_row) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q    <= '0;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (fire && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (fire) beat_q <= CW'(1);
                    ptr_q <= '0;
                end
                COLLECT: begin
                    if (bus.valid) beat_q <= (state_d == DRAIN) ? '0 : beat_q + CW'(1);
                    ptr_q <= '0;
                end
                DRAIN: begin
                    if (bus.out_ready) ptr_q <= last_row ? '0 : ptr_q + 3'd1;
                end
                default: begin
                    beat_q <= '0;
                    ptr_q  <= '0;
                end
            endcase
        end
    end

    // Column 1 trails column 0 by one beat, so it lands one row behind.
    assign wr0_en  = (state_q == COLLECT) && bus.valid &&
                     (beat_q >= CW'(LAT)) && (beat_q < CW'(LAT + ROWS));
    assign wr1_en  = (state_q == COLLECT) && bus.valid &&
                     (beat_q > CW'(LAT)) && (beat_q <= CW'(LAT + ROWS));
    assign wr0_row = RW'(beat_q - CW'(LAT));
    assign wr1_row = RW'(beat_q - CW'(LAT + 1));

    acc_tile_buffer #(
        .ROWS (ROWS),
        .RW   (RW)
    ) u_tile (
        .clk      (clk),
        .reset    (reset),
        .wr0_en   (wr0_en),
        .wr0_row  (wr0_row),
        .wr0_data (bus.acc_in1),
        .wr1_en   (wr1_en),
        .wr1_row  (wr1_row),
        .wr1_data (bus.acc_in2),
        .rd_row   (ptr_q[RW-1:0]),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1)
    );

    assign bus.out_valid = drain;
    assign bus.out_data0 = drain ? rd_data0 : '0;
    assign bus.out_data1 = drain ? rd_data1 : '0;
    assign bus.out_row   = ptr_q;
    assign bus.out_last  = drain && last_row;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_acc_collector.sv
// Directed scoreboard bench for acc_collector with ROWS=2, LAT=2.
module tb_acc_collector;
    import acc_collector_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    acc_collector_if bus();

    acc_collector #(
        .ROWS (2),
        .LAT  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [2:0]  row;
        logic        last;
    } row_t;

    row_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic push_tile(input logic [31:0] a, b, c, d);
        row_t r;
        r.d0 = a; r.d1 = b; r.row = 3'd0; r.last = 1'b0; exp_q.push_back(r);
        r.d0 = c; r.d1 = d; r.row = 3'd1; r.last = 1'b1; exp_q.push_back(r);
    endtask

    task automatic drive(input logic s, input logic v, input logic [31:0] a1, input logic [31:0] a2);
        bus.start   = s;
        bus.valid   = v;
        bus.acc_in1 = a1;
        bus.acc_in2 = a2;
        @(posedge clk);
        #1;
    endtask

    // Tile {a,b},{c,d}; stalls inserted between beat 2 and beat 3.
    task automatic run_tile(input logic [31:0] a, b, c, d, input int stalls);
        drive(1'b1, 1'b1, 32'h0, 32'h0);
        check("busy_rise", 32'(bus.busy), 32'd1);
        drive(1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b0, 1'b1, a, 32'h0);
        for (int i = 0; i < stalls; i++) drive(1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, c, b);
        check("out_valid_early", 32'(bus.out_valid), 32'd0);
        drive(1'b0, 1'b1, 32'h0, d);
        check("out_valid_rise", 32'(bus.out_valid), 32'd1);
        bus.valid = 1'b0;
    endtask

    task automatic drain_wait();
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < 20) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            k++;
        end
        check("drain_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data0"}, bus.out_data0, 32'd0);
        check({tag, "_out_data1"}, bus.out_data1, 32'd0);
        check({tag, "_out_row"},   32'(bus.out_row), 32'd0);
        check({tag, "_out_last"},  32'(bus.out_last), 32'd0);
        check({tag, "_busy"},      32'(bus.busy), 32'd0);
        check({tag, "_overrun"},   32'(bus.overrun), 32'd0);
    endtask

    // Monitor: every accepted row is popped from the scoreboard and compared.
    initial begin
        row_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_row: got row %0d, expected no row", bus.out_row);
                end else begin
                    e = exp_q.pop_front();
                    check("row_data0", bus.out_data0, e.d0);
                    check("row_data1", bus.out_data1, e.d1);
                    check("row_index", 32'(bus.out_row), 32'(e.row));
                    check("row_last",  32'(bus.out_last), 32'(e.last));
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.valid     = 1'b0;
        bus.acc_in1   = '0;
        bus.acc_in2   = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic tile, continuous valid.
        bus.out_ready = 1'b1;
        push_tile(32'd100, 32'd200, 32'd300, 32'd400);
        run_tile(32'd100, 32'd200, 32'd300, 32'd400, 0);
        drain_wait();

        // Two stalled beats between b2 and b3.
        push_tile(32'd100, 32'd200, 32'd300, 32'd400);
        run_tile(32'd100, 32'd200, 32'd300, 32'd400, 2);
        drain_wait();

        // Consumer back-pressure for 3+ cycles.
        bus.out_ready = 1'b0;
        push_tile(32'd5, 32'd6, 32'd15, 32'd16);
        run_tile(32'd5, 32'd6, 32'd15, 32'd16, 0);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data0", bus.out_data0, 32'd5);
            check("stall_data1", bus.out_data1, 32'd6);
            check("stall_row",   32'(bus.out_row), 32'd0);
            drive(1'b0, 1'b0, 32'h0, 32'h0);
        end
        bus.out_ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("consec_row1",   32'(bus.out_row), 32'd1);
        check("consec_valid",  32'(bus.out_valid), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("consec_idle",   32'(bus.busy), 32'd0);

        // Dropped starts during COLLECT and on the last-row handshake.
        push_tile(32'd11, 32'd22, 32'd33, 32'd44);
        drive(1'b1, 1'b1, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 32'h0, 32'h0);
        check("overrun_set", 32'(bus.overrun), 32'd1);
        drive(1'b0, 1'b1, 32'd11, 32'h0);
        drive(1'b0, 1'b1, 32'd33, 32'd22);
        drive(1'b0, 1'b1, 32'h0, 32'd44);
        check("ovr_out_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("ovr_last", 32'(bus.out_last), 32'd1);
        drive(1'b1, 1'b1, 32'h0, 32'h0);
        check("ovr_start_dropped", 32'(bus.busy), 32'd0);
        check("overrun_sticky", 32'(bus.overrun), 32'd1);

        // Next start accepted the cycle IDLE is reached; extreme values.
        push_tile(32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF);
        run_tile(32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        drain_wait();

        // Asynchronous reset at b3 of a tile.
        drive(1'b1, 1'b1, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 32'd55, 32'h0);
        bus.start   = 1'b0;
        bus.valid   = 1'b1;
        bus.acc_in1 = 32'd66;
        bus.acc_in2 = 32'd77;
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("midreset");
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.valid = 1'b0;
        @(posedge clk);
        #1;
        push_tile(32'd7, 32'd8, 32'd9, 32'd10);
        run_tile(32'd7, 32'd8, 32'd9, 32'd10, 0);
        drain_wait();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/acc_collector.md
# acc_collector

Output-side companion to the 2x2 systolic matrix unit. It watches the two column accumulator outputs, which leave the array skewed by one beat per column. It captures them into a ROWS x 2 result tile in matrix order, then drains the tile row by row over a valid/ready stream. It sits directly after the array and shares the array's `valid` beat strobe, so array stalls are tracked exactly.

## Interface
Parameters:
- `ROWS`, 2: rows of the input matrix streamed per tile; legal range 1..8.
- `LAT`, 2: valid beats from the start beat to the first column-0 result; must be ≥1.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `valid` input, 1 bit: array beat strobe; the same signal the array receives.
- `start` input, 1 bit: marks beat 0 of a tile; only meaningful together with `valid`.
- `acc_in1` input, 32 bits: column-0 accumulator from the bottom-left PE.
- `acc_in2` input, 32 bits: column-1 accumulator from the bottom-right PE.
- `out_valid` output, 1 bit: a result row is presented.
- `out_ready` input, 1 bit: the consumer accepts the presented row.
- `out_data0` output, 32 bits: column-0 value of the presented row.
- `out_data1` output, 32 bits: column-1 value of the presented row.
- `out_row` output, 3 bits: index of the presented row.
- `out_last` output, 1 bit: the presented row is row ROWS-1.
- `busy` output, 1 bit: high when the block is not in IDLE.
- `overrun` output, 1 bit: sticky; a start was dropped.

## Operation
- State machine has three states: IDLE, COLLECT and DRAIN.
- IDLE:
  - `busy`=0 and `out_valid`=0.
  - `start`&`valid` moves to COLLECT and sets the beat counter b=1 for the next beat; the start beat is b=0.
  - `start` without `valid` is ignored.
- COLLECT:
  - Each cycle with `valid`=1 is beat b; b increments after the beat.
  - Cycles with `valid`=0 hold b and capture nothing.
  - At beat b=LAT+r (r<ROWS), write `acc_in1` to tile[r][0].
  - At beat b=LAT+r+1 (r<ROWS), write `acc_in2` to tile[r][1].
  - A single beat can write col0 of row r and col1 of row r-1 together.
  - After beat LAT+ROWS, move to DRAIN with the read pointer at 0.
- DRAIN:
  - `out_valid`=1; present tile[ptr] on `out_data0`/`out_data1` with `out_row`=ptr and `out_last`=(ptr==ROWS-1).
  - On `out_valid`&`out_ready`, ptr increments.
  - On a handshake with `out_last`=1, return to IDLE.
  - While `out_ready`=0, all outputs hold stable.
  - `valid` and `acc_in*` are ignored in this state.
- Values are stored verbatim as 32-bit two's complement, with no arithmetic or saturation.
- A `start`&`valid` while `busy`=1 is dropped and sets `overrun`. This includes the final drain handshake cycle. `overrun` clears only on reset.
- Reset, including mid-tile, sets the state to IDLE and clears b, ptr and the tile to 0. All outputs go to 0.

## Timing
- Reset value of every output is 0.
- With continuous `valid`, where the start beat is cycle 0:
  - Last capture happens at cycle LAT+ROWS.
  - `out_valid` rises at cycle LAT+ROWS+1.
- Each stalled (`valid`=0) cycle during COLLECT adds one cycle of latency.
- Drain throughput is one row per cycle when `out_ready` is held high.
- IDLE is reached the cycle after the last handshake. The earliest accepted next `start` is that cycle.
- `out_*` are driven from registers or the registered tile, with no combinational path from any input.

## Structure
- The shared package holds:
  - the state enum (IDLE, COLLECT, DRAIN);
  - the default values of `ROWS` and `LAT`;
  - the accumulator width constant (32), shared with the array;
  - the counter-width function (`$clog2(LAT+ROWS+1)`).
- One natural sub-module, `acc_tile_buffer`:
  - ROWS x 2 x 32-bit register file;
  - two independent write ports, one per column, each with a row index;
  - one row-wide read port.
- The FSM and counters stay in `acc_collector`.

## Test plan
- LAT=2, ROWS=2, continuous `valid`. Drive `acc_in1` with 100 at b2 and 300 at b3; drive `acc_in2` with 200 at b3 and 400 at b4. Expect `out_valid` at cycle 5 with row0={100,200}, then row1={300,400} with `out_last`=1.
- Same data with `valid`=0 inserted for 2 cycles between b2 and b3. Expect identical tile values and `out_valid` at cycle 7.
- Hold `out_ready`=0 for 3 cycles in DRAIN. Expect row0 to stay stable throughout, then row0 and row1 to drain in consecutive cycles.
- Assert `start`&`valid` during COLLECT and again on the last-row handshake cycle. Expect `overrun`=1 and the current tile unaffected. A `start` the following cycle is accepted (`busy` rises).
- Assert reset at b3 mid-tile. Expect all outputs 0 and the state IDLE. A new tile with values 7/8/9/10 then drains as {7,8},{9,10} with no stale data.
- Use negative values: -1 (0xFFFFFFFF) and 0x80000000 round-trip bit-exact.
